// File: rtl/fifo_sync_pkg.sv
// Shared defaults and mode constants for the synchronous FIFO.
package fifo_sync_pkg;
    localparam int DEF_ADDR_SIZE = 4;
    localparam int DEF_DATA_SIZE = 8;
    localparam int DEF_AF_LEVEL  = 12;
    localparam int DEF_AE_LEVEL  = 4;

    localparam int FWFT_OFF = 0;
    localparam int FWFT_ON  = 1;
endpackage

// File: rtl/fifo_sync_ram.sv
// FIFO storage: synchronous write, asynchronous read, contents never reset.
module fifo_sync_ram
    import fifo_sync_pkg::*;
#(
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int DATA_SIZE = DEF_DATA_SIZE
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [ADDR_SIZE-1:0] waddr_i,
    input  logic [DATA_SIZE-1:0] wdata_i,
    input  logic [ADDR_SIZE-1:0] raddr_i,
    output logic [DATA_SIZE-1:0] rdata_o
);
    logic [DATA_SIZE-1:0] mem_q [2**ADDR_SIZE];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO with registered flags, error pulses and selectable
// registered-read or first-word-fall-through output.
module fifo_sync
    import fifo_sync_pkg::*;
#(
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int AF_LEVEL  = DEF_AF_LEVEL,
    parameter int AE_LEVEL  = DEF_AE_LEVEL,
    parameter int FWFT      = FWFT_OFF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [DATA_SIZE-1:0] wr_data,
    input  logic                 rd_en,
    output logic [DATA_SIZE-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_SIZE:0]   count,
    output logic                 overflow,
    output logic                 underflow
);
    localparam int DEPTH = 1 << ADDR_SIZE;
    localparam int PW    = ADDR_SIZE + 1;

    localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);
    localparam logic [PW-1:0] AF_CNT   = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_CNT   = PW'(AE_LEVEL);

    if (!(AE_LEVEL >= 0 && AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_bad_levels
        $error("fifo_sync: thresholds must satisfy 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]        count_d;
    logic                 full_q, empty_q, afull_q, aempty_q;
    logic                 ovf_q, udf_q;
    logic                 wr_acc, rd_acc;
    logic [DATA_SIZE-1:0] head;

    // Acceptance uses only the registered flags, so a pop never frees a slot
    // for a same-cycle push (and vice versa).
    always_comb begin
        wr_acc   = wr_en && !full_q;
        rd_acc   = rd_en && !empty_q;
        wr_ptr_d = wr_ptr_q + PW'(wr_acc);
        rd_ptr_d = rd_ptr_q + PW'(rd_acc);
        count_d  = wr_ptr_d - rd_ptr_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= (count_d == FULL_CNT);
            empty_q  <= (count_d == '0);
            afull_q  <= (count_d >= AF_CNT);
            aempty_q <= (count_d <= AE_CNT);
            ovf_q    <= wr_en && full_q;
            udf_q    <= rd_en && empty_q;
        end
    end

    fifo_sync_ram #(
        .ADDR_SIZE (ADDR_SIZE),
        .DATA_SIZE (DATA_SIZE)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q[ADDR_SIZE-1:0]),
        .wdata_i (wr_data),
        .raddr_i (rd_ptr_q[ADDR_SIZE-1:0]),
        .rdata_o (head)
    );

    if (FWFT == FWFT_ON) begin : g_fwft
        assign rd_data  = head;
        assign rd_valid = !empty_q;
    end else begin : g_regread
        logic [DATA_SIZE-1:0] rd_data_q;
        logic                 rd_valid_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_acc;
                if (rd_acc) begin
                    rd_data_q <= head;
                end
            end
        end

        assign rd_data  = rd_data_q;
        assign rd_valid = rd_valid_q;
    end

    assign count        = wr_ptr_q - rd_ptr_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;
endmodule

// File: doc/fifo_sync.md
FIFO_SYNC -- requirements
Module: fifo_sync

Interface
REQ-001 Parameter ADDR_SIZE, default 4: address width; depth = 2**ADDR_SIZE.
REQ-002 Parameter DATA_SIZE, default 8: word width.
REQ-003 Parameter AF_LEVEL, default 12: almost_full threshold in words, range 1..DEPTH.
REQ-004 Parameter AE_LEVEL, default 4: almost_empty threshold in words, range 0..DEPTH-1.
REQ-005 Parameter FWFT, default 0: 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-006 One clock and one asynchronous, active-high reset; ports listed below.
REQ-007 clk  in  1  sole clock; all state changes on rising edge.
REQ-008 rst  in  1  asynchronous active-high reset.
REQ-009 wr_en  in  1  write request.
REQ-010 wr_data  in  DATA_SIZE  write word.
REQ-011 rd_en  in  1  read/pop request.
REQ-012 rd_data  out  DATA_SIZE  read word.
REQ-013 rd_valid  out  1  rd_data qualifier.
REQ-014 full, empty  out  1 each  occupancy flags.
REQ-015 almost_full, almost_empty  out  1 each  threshold flags.
REQ-016 count  out  ADDR_SIZE+1  current occupancy, 0..DEPTH.
REQ-017 overflow, underflow  out  1 each  one-cycle error pulses.

Function
REQ-018 Write accepted iff wr_en && !full; read accepted iff rd_en && !empty; both use the registered flags of the current cycle.
REQ-019 Write and read pointers are ADDR_SIZE+1-bit binary; the low ADDR_SIZE bits address memory; wrap at 2**(ADDR_SIZE+1) with no special case.
REQ-020 count next = count + accepted write - accepted read; simultaneous accepted read and write leaves count unchanged.
REQ-021 Flags are registered from next count: full = (DEPTH), empty = (0), almost_full = (>= AF_LEVEL), almost_empty = (<= AE_LEVEL).
REQ-022 Full: write rejected even if a read is accepted the same cycle; the read proceeds and full deasserts next cycle.
REQ-023 Empty: read rejected even if a write is accepted the same cycle; the write proceeds and empty deasserts next cycle.
REQ-024 overflow pulses high one cycle after wr_en while full; underflow pulses high one cycle after rd_en while empty; no state change on a rejected request.
REQ-025 FWFT=0: on an accepted read, rd_data is registered with the head word and rd_valid is high for exactly the following cycle; otherwise rd_data holds and rd_valid is 0.
REQ-026 FWFT=1: rd_data = head word combinationally, rd_valid = !empty; an accepted read pops, and the next word appears in the following cycle.
REQ-027 Write-to-first-visibility latency: 1 cycle (empty deasserts) in FWFT=1; 2 cycles to rd_valid in FWFT=0, given rd_en asserted.

Reset
REQ-028 On rst, immediately: pointers = 0, count = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0, overflow = underflow = 0, rd_valid = 0, rd_data = 0 (FWFT=0).
REQ-029 Memory contents are not reset; asserting rst mid-operation discards all stored words.
REQ-030 The first write is accepted on the first rising edge after rst deasserts.

Structure
REQ-031 A shared package holds the default ADDR_SIZE/DATA_SIZE values and the FWFT mode constants.
REQ-032 The storage array is a single sub-module, fifo_sync_ram: synchronous write, asynchronous read, no reset.
REQ-033 Parameter legality (AE_LEVEL < AF_LEVEL <= DEPTH) is checked at elaboration.

Verification
REQ-034 Fill test: reset, then 16 writes of 0x00..0x0F with no reads -> count = 16, full = 1, almost_full high from count 12; a 17th write -> overflow pulse, count stays 16.
REQ-035 Drain test (FWFT=0): from full, rd_en held 16 cycles -> rd_data 0x00..0x0F in order, each with rd_valid one cycle after its read, then empty = 1; an extra rd_en -> underflow pulse.
REQ-036 Simultaneous read/write at count 5, 100 cycles -> count stays 5, data order preserved; pointers wrap at least 6 times.
REQ-037 Boundary cases: wr_en and rd_en together while full -> count 15, full = 0; together while empty -> count 1, no read, underflow pulse.
REQ-038 FWFT=1: write 0xA5 into an empty FIFO -> the next cycle rd_valid = 1 and rd_data = 0xA5 with no rd_en; pop -> empty = 1.
REQ-039 Reset mid-stream: assert rst at count 9 -> all outputs take their REQ-028 values without waiting for a clock edge.
